uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   8N1 UART receiver. Pairs with the TX-only UART peripheral.
//   Synchronises the asynchronous rx line and samples each bit at mid-bit.
//   Buffers received bytes in a small FIFO that is drained through a valid/ready handshake.
//   Reports framing errors and overruns. Sits between the uart_rx pin and the UART
//   peripheral's DATA/CSR read path.
// PARAMETERS
//   BAUDRATE_DIV  434  bit period = BAUDRATE_DIV+1 clk_i cycles (434 -> 115200 @ 50 MHz)
//   FIFO_DEPTH    4    receive FIFO entries; power of 2, >= 2
// PORTS
//   clk_i        in   1               clock
//   reset_n_i    in   1               asynchronous, active-low reset
//   uart_rx_i    in   1               serial input, idle high, asynchronous to clk_i
//   data_o       out  8               FIFO head byte; valid only while valid_o=1
//   valid_o      out  1               FIFO not empty
//   ready_i      in   1               consumer pop; pop occurs when valid_o && ready_i
//   level_o      out  log2(DEPTH)+1   current FIFO occupancy
//   frame_err_o  out  1               one-cycle pulse: stop bit sampled as 0
//   overrun_o    out  1               sticky: a byte was dropped because the FIFO was full
//   clr_i        in   1               synchronous clear of overrun_o
// BEHAVIOUR
//   Reset (async, reset_n_i=0): all state is cleared immediately.
//     - Synchroniser flops = 1, FSM = IDLE, counters = 0, FIFO empty.
//     - valid_o=0, level_o=0, frame_err_o=0, overrun_o=0, data_o=0.
//     - Reset mid-frame abandons the frame. The partial byte is discarded.
//   Input sync: 2-flop synchroniser -> rx_s. All decisions use rx_s only (2-cycle input latency).
//   Counter br_cnt: runs 0..BAUDRATE_DIV and then wraps to 0. Cleared on every state change.
//   FSM:
//     IDLE  : rx_s==0 -> START.
//     START : at br_cnt==BAUDRATE_DIV/2 (floor), sample rx_s.
//             - rx_s==0 -> DATA; br_cnt=0, bit_cnt=0.
//             - rx_s==1 -> IDLE. This is a glitch: nothing is flagged.
//     DATA  : at br_cnt==BAUDRATE_DIV, shift rx_s in, LSB first.
//             After the 8th sample -> STOP.
//     STOP  : at br_cnt==BAUDRATE_DIV, sample rx_s.
//             - rx_s==1 -> push byte; -> IDLE.
//             - rx_s==0 -> frame_err_o=1 for exactly 1 cycle; byte is discarded; -> BREAK.
//     BREAK : wait for rx_s==1 -> IDLE. A held-low line does not retrigger a frame.
//   Sampling point: START checks at half-bit. Later samples land at mid-bit,
//     spaced BAUDRATE_DIV+1 cycles apart.
//   Push timing: the push takes effect at the clock edge following the stop sample.
//     valid_o/level_o reflect it on that edge.
//   FIFO:
//     - data_o is the registered head entry.
//     - A pop advances head on the clock edge.
//     - Pointers wrap modulo FIFO_DEPTH; occupancy tracked in level_o.
//   Simultaneous push+pop:
//     - level_o unchanged.
//     - When full, the push is accepted and no overrun is flagged.
//   Push while full without pop: the byte is dropped and overrun_o is set (sticky).
//     FIFO contents are unchanged.
//   clr_i: clears overrun_o the next edge. If clr_i and a new overrun coincide, overrun_o stays 1.
//   Pop while empty (ready_i=1, valid_o=0): no effect.
//   A frame_err_o pulse never coincides with a push.
// TESTING (bench with BAUDRATE_DIV=15, FIFO_DEPTH=4; one bit = 16 cycles)
//   1. Send 0x55 8N1 -> data_o=0x55, valid_o=1, level_o=1 one edge after stop sample;
//      frame_err_o=0. ready_i=1 -> valid_o=0.
//   2. Drive uart_rx_i low for 5 cycles, then high -> FSM returns to IDLE;
//      no push, no frame_err_o.
//   3. Send 0xA3 with stop bit 0, hold line low 3 bit times, then high,
//      then send 0x3C -> one frame_err_o pulse; FIFO holds only 0x3C.
//   4. ready_i=0; send 0x01..0x05 -> level_o=4, overrun_o=1.
//      Pops yield 0x01,0x02,0x03,0x04. clr_i -> overrun_o=0.
//   5. FIFO full; ready_i=1 on the push edge of the next byte 0x77 -> overrun_o stays 0,
//      level_o stays 4, 0x77 is the last entry.
//   6. Assert reset_n_i mid-DATA of 0x9E -> outputs at reset values with no clock edge.
//      After release, 0x9E is sent in full and received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with a small receive FIFO.
//
// The asynchronous rx pin is brought into the clk_i domain via a two-flop
// synchroniser. A bit-rate counter places the start-bit check at half a bit
// period and every later sample at mid-bit. Received bytes go into a FIFO that
// is drained through a valid/ready handshake.
//
// Ports
//   clk_i        in   clock
//   reset_n_i    in   asynchronous active-low reset
//   uart_rx_i    in   serial input, idle high, asynchronous to clk_i
//   data_o       out  [7:0] FIFO head byte, meaningful while valid_o=1
//   valid_o      out  FIFO not empty
//   ready_i      in   consumer pop, taken when valid_o && ready_i
//   level_o      out  [log2(FIFO_DEPTH):0] FIFO occupancy
//   frame_err_o  out  one-cycle pulse: stop bit sampled low
//   overrun_o    out  sticky: a byte was dropped because the FIFO was full
//   clr_i        in   synchronous clear of overrun_o
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned BAUDRATE_DIV = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         uart_rx_i,
    output logic [7:0]                   data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(FIFO_DEPTH):0]  level_o,
    output logic                         frame_err_o,
    output logic                         overrun_o,
    input  logic                         clr_i
);

    localparam int unsigned CNT_W = $clog2(BAUDRATE_DIV + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] BR_FULL = CNT_W'(BAUDRATE_DIV);
    localparam logic [CNT_W-1:0] BR_HALF = CNT_W'(BAUDRATE_DIV / 2);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic [1:0]       sync_q, sync_d;
    logic             rx_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             frame_err_q, frame_err_d;
    logic             push_s;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             valid_q, valid_d;
    logic [7:0]       data_q, data_d;
    logic             overrun_q, overrun_d;
    logic             full_s, pop_s, wr_en_s, drop_s;

    // Synchroniser: shift the raw pin through two flops; rx_s is the only
    // version of the line the receiver ever looks at.
    always_comb begin
        sync_d = {sync_q[0], uart_rx_i};
    end

    assign rx_s = sync_q[1];

    // Receive FSM: next state, bit-rate counter, data shifter, push/error strobes.
    always_comb begin
        state_d     = state_q;
        br_cnt_d    = (br_cnt_q == BR_FULL) ? {CNT_W{1'b0}} : br_cnt_q + CNT_W'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push_s      = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                // A start bit still low at half-bit is real; otherwise it was a glitch.
                if (br_cnt_q == BR_HALF) begin
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (br_cnt_q == BR_FULL) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (br_cnt_q == BR_FULL) begin
                    if (rx_s) begin
                        push_s  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_BREAK: begin
                // Stay here while the line is held low so it cannot retrigger a frame.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every state change restarts the bit-rate counter.
        if (state_d != state_q) begin
            br_cnt_d = {CNT_W{1'b0}};
        end else begin
            br_cnt_d = br_cnt_d;
        end
    end

    // FIFO bookkeeping: push/pop arbitration, pointers, occupancy, overrun, head.
    always_comb begin
        full_s  = (level_q == LVL_MAX);
        pop_s   = ready_i && (level_q != {LVL_W{1'b0}});
        // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
        wr_en_s = push_s && (!full_s || pop_s);
        drop_s  = push_s && full_s && !pop_s;

        mem_d = mem_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // A new drop wins over a coincident clear.
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (clr_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        valid_d = (level_d != {LVL_W{1'b0}});
        // Head is taken from the post-update array so a write into an empty
        // FIFO appears on data_o on the same edge as valid_o.
        data_d  = mem_d[rd_ptr_d];
    end

    // State register for synchroniser, FSM, shifter and FIFO.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q      <= 2'b11;
            state_q     <= ST_IDLE;
            br_cnt_q    <= {CNT_W{1'b0}};
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
            mem_q       <= '{default: 8'h00};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            level_q     <= {LVL_W{1'b0}};
            valid_q     <= 1'b0;
            data_q      <= 8'h00;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            br_cnt_q    <= br_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign level_o     = level_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx (BAUDRATE_DIV=15, FIFO_DEPTH=4).
//
// The sender drives 16-cycle bits starting on a falling clock edge. For a frame
// whose start bit is driven right after clock edge n, the stop-bit outcome
// (push or frame error) is visible from clock edge n+155 onward. The sender
// records that outcome in an event table keyed by edge number; a queue-based
// FIFO model consumes the table and the handshake inputs, and a compare
// process checks every DUT output against it on each falling edge.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       uart_rx_i;
    logic       ready_i;
    logic       clr_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic [2:0] level_o;
    logic       frame_err_o;
    logic       overrun_o;

    uart_rx #(.BAUDRATE_DIV(15), .FIFO_DEPTH(4)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .uart_rx_i   (uart_rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .level_o     (level_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .clr_i       (clr_i)
    );

    always #5 clk_i = ~clk_i;

    // Edge counter: value read at a falling edge = number of rising edges so far.
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Expected stop-bit outcomes: 1 = push byte, 2 = frame error; keyed by cyc value seen at that edge.
    int         ev_kind [int];
    logic [7:0] ev_data [int];

    // Reference model state.
    logic [7:0] mq [$];
    bit         m_ferr;
    bit         m_ovr;

    int n_checks = 0;
    int n_err    = 0;
    int ferr_cnt = 0;
    bit rand_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_loop();
        bit         push, ferr, pop, full;
        logic [7:0] pd;
        forever begin
            @(posedge clk_i or negedge reset_n_i);
            if (!reset_n_i) begin
                mq.delete();
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end else begin
                push = 1'b0;
                ferr = 1'b0;
                pd   = 8'h00;
                if (ev_kind.exists(cyc)) begin
                    if (ev_kind[cyc] == 1) begin
                        push = 1'b1;
                        pd   = ev_data[cyc];
                    end else begin
                        ferr = 1'b1;
                    end
                end
                pop  = ready_i && (mq.size() != 0);
                full = (mq.size() == 4);
                if (clr_i) m_ovr = 1'b0;
                if (pop) void'(mq.pop_front());
                if (push) begin
                    if (!full || pop) mq.push_back(pd);
                    else m_ovr = 1'b1;
                end
                m_ferr = ferr;
            end
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk_i);
            if (reset_n_i) begin
                chk("valid", 32'(valid_o), 32'(mq.size() != 0));
                chk("level", 32'(level_o), 32'(mq.size()));
                chk("frame_err", 32'(frame_err_o), 32'(m_ferr));
                chk("overrun", 32'(overrun_o), 32'(m_ovr));
                if (mq.size() != 0) chk("data", 32'(data_o), 32'(mq[0]));
                if (frame_err_o) ferr_cnt++;
            end
        end
    endtask

    // Send one 8N1 frame starting at the current falling edge. abort_at >= 0
    // stops driving after that many cycles; pop_at_push raises ready_i for
    // exactly the edge on which the byte is pushed.
    task automatic send(input logic [7:0] b, input bit stop_ok, input int abort_at, input bit pop_at_push);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        ev_kind[cyc + 154] = stop_ok ? 1 : 2;
        ev_data[cyc + 154] = b;
        for (int t = 0; t < 160; t++) begin
            if (t == abort_at) return;
            uart_rx_i = fr[t / 16];
            if (pop_at_push) ready_i = (t == 154);
            @(negedge clk_i);
        end
    endtask

    task automatic idle(input int n);
        uart_rx_i = 1'b1;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic pop_one();
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
    endtask

    task automatic reset_mid_frame();
        int keys [$];
        #2;
        reset_n_i = 1'b0;
        uart_rx_i = 1'b1;
        ready_i   = 1'b0;
        clr_i     = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_ferr", 32'(frame_err_o), 32'd0);
        chk("rst_ovr", 32'(overrun_o), 32'd0);
        foreach (ev_kind[k]) if (k >= cyc) keys.push_back(k);
        foreach (keys[i]) begin
            ev_kind.delete(keys[i]);
            ev_data.delete(keys[i]);
        end
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;
        idle(10);
    endtask

    initial begin
        int base;
        reset_n_i = 1'b0;
        uart_rx_i = 1'b1;
        ready_i   = 1'b0;
        clr_i     = 1'b0;
        rand_done = 1'b0;
        fork
            model_loop();
            compare_loop();
        join_none
        repeat (3) @(negedge clk_i);
        chk("init_valid", 32'(valid_o), 32'd0);
        chk("init_level", 32'(level_o), 32'd0);
        chk("init_data", 32'(data_o), 32'd0);
        chk("init_ovr", 32'(overrun_o), 32'd0);
        reset_n_i = 1'b1;
        idle(5);

        // 1: single good byte, then pop
        send(8'h55, 1'b1, -1, 1'b0);
        chk("t1_data", 32'(data_o), 32'h55);
        chk("t1_valid", 32'(valid_o), 32'd1);
        chk("t1_level", 32'(level_o), 32'd1);
        chk("t1_ferr_cnt", 32'(ferr_cnt), 32'd0);
        pop_one();
        chk("t1_popped", 32'(valid_o), 32'd0);

        // 2: 5-cycle glitch
        uart_rx_i = 1'b0;
        repeat (5) @(negedge clk_i);
        idle(40);
        chk("t2_level", 32'(level_o), 32'd0);
        chk("t2_ferr_cnt", 32'(ferr_cnt), 32'd0);

        // 3: framing error, break, then good byte
        base = ferr_cnt;
        send(8'hA3, 1'b0, -1, 1'b0);
        uart_rx_i = 1'b0;
        repeat (48) @(negedge clk_i);
        idle(20);
        send(8'h3C, 1'b1, -1, 1'b0);
        chk("t3_ferr_pulses", 32'(ferr_cnt - base), 32'd1);
        chk("t3_level", 32'(level_o), 32'd1);
        chk("t3_data", 32'(data_o), 32'h3C);
        pop_one();

        // 4: overrun
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, -1, 1'b0);
        chk("t4_level", 32'(level_o), 32'd4);
        chk("t4_ovr", 32'(overrun_o), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("t4_pop_data", 32'(data_o), 32'(i));
            pop_one();
        end
        chk("t4_empty", 32'(valid_o), 32'd0);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        chk("t4_clr", 32'(overrun_o), 32'd0);

        // 5: push while full with simultaneous pop
        for (int i = 1; i <= 4; i++) send(8'(8'h10 + i), 1'b1, -1, 1'b0);
        chk("t5_full", 32'(level_o), 32'd4);
        send(8'h77, 1'b1, -1, 1'b1);
        chk("t5_level", 32'(level_o), 32'd4);
        chk("t5_ovr", 32'(overrun_o), 32'd0);
        chk("t5_d0", 32'(data_o), 32'h12); pop_one();
        chk("t5_d1", 32'(data_o), 32'h13); pop_one();
        chk("t5_d2", 32'(data_o), 32'h14); pop_one();
        chk("t5_d3", 32'(data_o), 32'h77); pop_one();

        // 6: reset in the middle of DATA
        send(8'h42, 1'b1, -1, 1'b0);
        send(8'h9E, 1'b1, 60, 1'b0);
        reset_mid_frame();
        send(8'h9E, 1'b1, -1, 1'b0);
        chk("t6_level", 32'(level_o), 32'd1);
        chk("t6_data", 32'(data_o), 32'h9E);
        pop_one();

        // Randomized frames, gaps, stop bits, ready and clear
        fork
            begin
                for (int f = 0; f < 14; f++) begin
                    logic [7:0] b;
                    bit         ok;
                    b  = 8'($urandom);
                    ok = ($urandom_range(0, 7) != 0);
                    send(b, ok, -1, 1'b0);
                    if (!ok) begin
                        uart_rx_i = 1'b0;
                        repeat ($urandom_range(0, 40)) @(negedge clk_i);
                        idle(20 + $urandom_range(0, 10));
                    end else begin
                        idle($urandom_range(0, 24));
                    end
                end
                idle(20);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    ready_i = ($urandom_range(0, 2) == 0);
                    clr_i   = ($urandom_range(0, 31) == 0);
                    @(negedge clk_i);
                end
                ready_i = 1'b0;
                clr_i   = 1'b0;
            end
        join
        idle(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
